// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned TIME_W    = 2;
  localparam logic [1:0]  TUSE_NONE = 2'd3;

  localparam logic [31:0] EXC_VECTOR_DEFAULT  = 32'h0000_4180;
  localparam int unsigned MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic {StRun, StRecover} ctrl_state_e;

  // A producer blocks a consumer when its result arrives later than the consumer needs it.
  function automatic logic src_hazard(input logic [4:0] src, input logic [TIME_W-1:0] tuse,
                                      input logic [4:0] waddr_e, input logic [TIME_W-1:0] tnew_e,
                                      input logic [4:0] waddr_m, input logic [TIME_W-1:0] tnew_m);
    return (src != 5'd0) &&
           (((src == waddr_e) && (tnew_e > tuse)) || ((src == waddr_m) && (tnew_m > tuse)));
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Multiply/divide occupancy counter: loads on an MDU start, counts down to idle.
module mdu_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // A reload always wins, even over a count still in flight.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / PC-redirect sequencer for the F/D register and later stages.
// Optional feature: define HAZARD_STATS_EN to build the stall_cycles counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [TIME_W-1:0] tuse_rs_d,
  input  logic [TIME_W-1:0] tuse_rt_d,
  input  logic              md_use_d,
  input  logic [4:0]        waddr_e,
  input  logic [TIME_W-1:0] tnew_e,
  input  logic [4:0]        waddr_m,
  input  logic [TIME_W-1:0] tnew_m,
  input  logic              mdu_start_e,
  input  logic              mdu_div_e,
  input  logic              exc_req_m,
  input  logic              eret_m,
  input  logic [31:0]       epc_i,
  output logic              stall_fd,
  output logic              flush_de,
  output logic              flush_all,
  output logic              pc_redirect,
  output logic [31:0]       pc_target,
  output logic              mdu_busy,
  output logic [31:0]       stall_cycles
);

  ctrl_state_e state_d, state_q;
  logic        reg_stall, md_stall, stall;

  mdu_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (mdu_start_e && !exc_req_m && !eret_m),
    .is_div(mdu_div_e),
    .busy  (mdu_busy)
  );

  assign reg_stall = src_hazard(rs_d, tuse_rs_d, waddr_e, tnew_e, waddr_m, tnew_m) ||
                     src_hazard(rt_d, tuse_rt_d, waddr_e, tnew_e, waddr_m, tnew_m);
  assign md_stall  = md_use_d && (mdu_busy || mdu_start_e);
  assign stall     = (reg_stall || md_stall) && (state_q == StRun) && !exc_req_m && !eret_m
                     && !reset;

  always_comb begin
    state_d     = state_q;
    stall_fd    = 1'b0;
    flush_de    = 1'b0;
    flush_all   = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = EXC_VECTOR;
    if (!reset) begin
      unique case (state_q)
        StRun: begin
          if (exc_req_m) begin
            flush_all   = 1'b1;
            pc_redirect = 1'b1;
            state_d     = StRecover;
          end else if (eret_m) begin
            flush_all   = 1'b1;
            pc_redirect = 1'b1;
            pc_target   = epc_i;
            state_d     = StRecover;
          end else begin
            stall_fd = stall;
            flush_de = stall;
          end
        end
        // Commit slots here hold already-flushed instructions, so their requests are dropped.
        StRecover: begin
          pc_target = '0;
          state_d   = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_d, rt_d, waddr_e, waddr_m;
  logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic        md_use_d, mdu_start_e, mdu_div_e, exc_req_m, eret_m;
  logic [31:0] epc_i;
  logic        stall_fd, flush_de, flush_all, pc_redirect, mdu_busy;
  logic [31:0] pc_target, stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .tuse_rs_d   (tuse_rs_d),
    .tuse_rt_d   (tuse_rt_d),
    .md_use_d    (md_use_d),
    .waddr_e     (waddr_e),
    .tnew_e      (tnew_e),
    .waddr_m     (waddr_m),
    .tnew_m      (tnew_m),
    .mdu_start_e (mdu_start_e),
    .mdu_div_e   (mdu_div_e),
    .exc_req_m   (exc_req_m),
    .eret_m      (eret_m),
    .epc_i       (epc_i),
    .stall_fd    (stall_fd),
    .flush_de    (flush_de),
    .flush_all   (flush_all),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .mdu_busy    (mdu_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; rs_d = 5'd0; rt_d = 5'd0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3;
    md_use_d = 1'b0; waddr_e = 5'd0; tnew_e = 2'd0; waddr_m = 5'd0; tnew_m = 2'd0;
    mdu_start_e = 1'b0; mdu_div_e = 1'b0; exc_req_m = 1'b0; eret_m = 1'b0; epc_i = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    rs_d = 5'd1; tuse_rs_d = 2'd0; waddr_e = 5'd1; tnew_e = 2'd2;
    tick();
    #1;
    n_cmp++;
    if ({stall_fd, flush_de, flush_all, pc_redirect} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {stall_fd, flush_de, flush_all, pc_redirect});
    end
    n_cmp++;
    if (pc_target !== 32'h4180) begin
      n_err++; $display("FAIL reset_target: got %h want 00004180", pc_target);
    end
    n_cmp++;
    if ({mdu_busy, stall_cycles} !== 33'd0) begin
      n_err++; $display("FAIL reset_busy_stats: got busy=%b stats=%0d want 0/0", mdu_busy, stall_cycles);
    end
    idle();
    tick();
  endtask

  task automatic test_reg_hazard();
    idle();
    rs_d = 5'd1; rt_d = 5'd1; tuse_rs_d = 2'd1; tuse_rt_d = 2'd1; waddr_e = 5'd1; tnew_e = 2'd2;
    #1;
    n_cmp++;
    if ({stall_fd, flush_de, flush_all} !== 3'b110) begin
      n_err++; $display("FAIL load_use_stall: got %b want 110", {stall_fd, flush_de, flush_all});
    end
    tick();
    waddr_e = 5'd0; tnew_e = 2'd0; waddr_m = 5'd1; tnew_m = 2'd1;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b0) begin
      n_err++; $display("FAIL load_use_release: got %b want 0", stall_fd);
    end
    idle();
    rt_d = 5'd5; tuse_rt_d = 2'd0; waddr_m = 5'd5; tnew_m = 2'd1;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b1) begin
      n_err++; $display("FAIL rt_m_stall: got %b want 1", stall_fd);
    end
    idle();
    tuse_rs_d = 2'd0; waddr_e = 5'd0; tnew_e = 2'd2;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b0) begin
      n_err++; $display("FAIL zero_reg: got %b want 0", stall_fd);
    end
    idle();
    tick();
  endtask

  task automatic test_mdu_div();
    int n;
    idle();
    md_use_d = 1'b1; mdu_start_e = 1'b1; mdu_div_e = 1'b1;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b1) begin
      n_err++; $display("FAIL div_start_stall: got %b want 1", stall_fd);
    end
    tick();
    mdu_start_e = 1'b0; mdu_div_e = 1'b0;
    n = 0;
    while (mdu_busy === 1'b1 && n < 20) begin
      n_cmp++;
      if (stall_fd !== 1'b1) begin
        n_err++; $display("FAIL div_busy_stall: cycle %0d got %b want 1", n, stall_fd);
      end
      n++;
      tick();
    end
    n_cmp++;
    if (n != 10) begin
      n_err++; $display("FAIL div_busy_len: got %0d want 10", n);
    end
    n_cmp++;
    if (stall_fd !== 1'b0) begin
      n_err++; $display("FAIL div_release: got %b want 0", stall_fd);
    end
    idle();
    mdu_start_e = 1'b1;
    tick();
    mdu_start_e = 1'b0;
    n = 0;
    while (mdu_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 5) begin
      n_err++; $display("FAIL mult_busy_len: got %0d want 5", n);
    end
    mdu_start_e = 1'b1; mdu_div_e = 1'b1; exc_req_m = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (mdu_busy !== 1'b0) begin
      n_err++; $display("FAIL start_killed_by_exc: got %b want 0", mdu_busy);
    end
    tick();
  endtask

  task automatic test_exception();
    idle();
    rs_d = 5'd1; tuse_rs_d = 2'd1; waddr_e = 5'd1; tnew_e = 2'd2; exc_req_m = 1'b1;
    #1;
    n_cmp++;
    if ({flush_all, pc_redirect, stall_fd, flush_de} !== 4'b1100 || pc_target !== 32'h4180) begin
      n_err++; $display("FAIL exc_flush: got %b tgt=%h want 1100 tgt=00004180",
                        {flush_all, pc_redirect, stall_fd, flush_de}, pc_target);
    end
    tick();
    #1;
    n_cmp++;
    if ({flush_all, pc_redirect, stall_fd, flush_de} !== 4'b0000) begin
      n_err++; $display("FAIL exc_recover: got %b want 0000", {flush_all, pc_redirect, stall_fd, flush_de});
    end
    tick();
    exc_req_m = 1'b0;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b1) begin
      n_err++; $display("FAIL back_to_run: got %b want 1", stall_fd);
    end
    idle();
    tick();
  endtask

  task automatic test_eret();
    idle();
    eret_m = 1'b1; epc_i = 32'h3010;
    #1;
    n_cmp++;
    if ({flush_all, pc_redirect} !== 2'b11 || pc_target !== 32'h3010) begin
      n_err++; $display("FAIL eret_redirect: got %b tgt=%h want 11 tgt=00003010", {flush_all, pc_redirect}, pc_target);
    end
    tick();
    idle();
    tick();
    eret_m = 1'b1; exc_req_m = 1'b1; epc_i = 32'h3010;
    #1;
    n_cmp++;
    if ({flush_all, pc_redirect} !== 2'b11 || pc_target !== 32'h4180) begin
      n_err++; $display("FAIL exc_over_eret: got %b tgt=%h want 11 tgt=00004180", {flush_all, pc_redirect}, pc_target);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    mdu_start_e = 1'b1; mdu_div_e = 1'b1;
    tick();
    idle();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; md_use_d = 1'b1;
    #1;
    n_cmp++;
    if ({mdu_busy, stall_fd} !== 2'b00) begin
      n_err++; $display("FAIL reset_mid_div: got busy/stall=%b want 00", {mdu_busy, stall_fd});
    end
    md_use_d = 1'b0; exc_req_m = 1'b1;
    #1;
    n_cmp++;
    if (flush_all !== 1'b1) begin
      n_err++; $display("FAIL reset_state_run: got %b want 1", flush_all);
    end
    idle();
    reset = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_stats();
    logic [31:0] exp;
    idle();
    reset = 1'b1;
    tick();
    idle();
    rs_d = 5'd2; tuse_rs_d = 2'd0; waddr_e = 5'd2; tnew_e = 2'd1;
    repeat (3) tick();
    idle();
    tick();
`ifdef HAZARD_STATS_EN
    exp = 32'd3;
`else
    exp = 32'd0;
`endif
    n_cmp++;
    if (stall_cycles !== exp) begin
      n_err++; $display("FAIL stall_stats: got %0d want %0d", stall_cycles, exp);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_reg_hazard();
    test_mdu_div();
    test_exception();
    test_eret();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
